// File: rtl/wb_uart_tx_pkg.sv
// Register map, STATUS bit positions, FSM encoding and reset divisor for wb_uart_tx.
// Shared by the top level and by anything that needs to decode its registers.
package wb_uart_tx_pkg;

   localparam logic [1:0] ADR_DATA   = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_DIV    = 2'd2;
   localparam logic [1:0] ADR_IRQEN  = 2'd3;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   localparam int DEFAULT_DIV = 4166;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a registered read port: the popped word appears on rd_data
// the clock after pop. Push and pop may coincide, including when the FIFO is full.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          push,
   input  logic [W-1:0]  wr_data,
   input  logic          pop,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  rd_data_q;
   logic          do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push  = push & ((count_q != FULL_CNT) | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
      if (do_pop)  rd_data_q     <= mem[rd_ptr_q];
   end

   assign rd_data = rd_data_q;
   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: TX FIFO, runtime divisor, STATUS with sticky overflow.
// Optional feature macro WB_UART_TX_IRQ_EN adds the IRQ_EN register at 0xC and the irq output.
module wb_uart_tx #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = wb_uart_tx_pkg::DEFAULT_DIV,
   parameter int DIV_W       = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        uart_tx
`ifdef WB_UART_TX_IRQ_EN
  ,output logic        irq
`endif
);
   import wb_uart_tx_pkg::*;

   localparam int               AW      = $clog2(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ovf_q, ovf_d;

   logic             req, wr_en;
   logic [1:0]       reg_sel;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [AW:0]      fifo_count;

   tx_state_e        state_q;
   logic [DIV_W-1:0] baud_q, fdiv_q;
   logic [2:0]       bit_q, bit_nxt;
   logic             tx_q;
   logic             busy_fsm, busy, baud_done;
   logic [31:0]      status, rdata;
   logic             unused_adr;

`ifdef WB_UART_TX_IRQ_EN
   logic [1:0]       irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
`endif

   assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

   always_comb begin
      req       = wbs_cyc_i & wbs_stb_i;
      ack_d     = req & ~ack_q;
      // Side effects land at the end of the ack cycle.
      wr_en     = req & ack_q & wbs_we_i;
      reg_sel   = wbs_adr_i[3:2];
      busy_fsm  = (state_q != S_IDLE);
      busy      = busy_fsm | ~fifo_empty;
      baud_done = (baud_q == '0);
      bit_nxt   = bit_q + 3'd1;
      fifo_pop  = ~fifo_empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_done));
      fifo_push = wr_en & (reg_sel == ADR_DATA) & wbs_sel_i[0];

      div_d = div_q;
      if (wr_en && (reg_sel == ADR_DIV))
         div_d = DIV_W'(merge_lanes(32'(div_q), wbs_dat_i, wbs_sel_i));

      ovf_d = ovf_q;
      if (wr_en && (reg_sel == ADR_STATUS) && wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
      if (fifo_push & fifo_full & ~fifo_pop) ovf_d = 1'b1;

      status                       = '0;
      status[ST_BUSY]              = busy;
      status[ST_FULL]              = fifo_full;
      status[ST_EMPTY]             = fifo_empty;
      status[ST_OVF]               = ovf_q;
      status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);

`ifdef WB_UART_TX_IRQ_EN
      irq_en_d = irq_en_q;
      if (wr_en && (reg_sel == ADR_IRQEN) && wbs_sel_i[0]) irq_en_d = wbs_dat_i[1:0];
      irq_d = (irq_en_q[0] & fifo_empty & ~busy_fsm) | (irq_en_q[1] & ovf_q);
`endif

      case (reg_sel)
         ADR_STATUS: rdata = status;
         ADR_DIV:    rdata = 32'(div_q);
`ifdef WB_UART_TX_IRQ_EN
         ADR_IRQEN:  rdata = 32'(irq_en_q);
`endif
         default:    rdata = '0;
      endcase

      dat_d = (ack_d & ~wbs_we_i) ? rdata : '0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         div_q <= DIV_RST;
         ovf_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         div_q <= div_d;
         ovf_q <= ovf_d;
      end
   end

`ifdef WB_UART_TX_IRQ_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8),
      .AW    (AW)
   ) u_fifo (
      .clk     (wb_clk_i),
      .srst    (wb_rst_i),
      .push    (fifo_push),
      .wr_data (wbs_dat_i[7:0]),
      .pop     (fifo_pop),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         fdiv_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else if (fifo_pop) begin
         // Same path for the idle pickup and the gapless handoff on STOP's last clock.
         state_q <= S_START;
         fdiv_q  <= div_q;
         baud_q  <= div_q;
         bit_q   <= '0;
         tx_q    <= 1'b0;
      end else begin
         case (state_q)
            S_START: begin
               if (baud_done) begin
                  state_q <= S_DATA;
                  baud_q  <= fdiv_q;
                  tx_q    <= fifo_dout[0];
               end else begin
                  baud_q <= baud_q - DIV_W'(1);
               end
            end
            S_DATA: begin
               if (baud_done) begin
                  baud_q <= fdiv_q;
                  bit_q  <= bit_nxt;
                  if (bit_nxt == 3'd0) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     tx_q <= fifo_dout[bit_nxt];
                  end
               end else begin
                  baud_q <= baud_q - DIV_W'(1);
               end
            end
            S_STOP: begin
               if (baud_done) state_q <= S_IDLE;
               else           baud_q  <= baud_q - DIV_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign uart_tx   = tx_q;

endmodule
